vector_list_player: RTL
=======================

Name: vector_list_player

Overview:
- Command initiator for the vector control block.
- Walks a display list held in synchronous RAM and decodes one word per command into x/y plus a single-cycle jump or draw strobe.
- Issues a strobe only when the downstream ready is high, and never issues two commands back to back.
- Sits between the frame-buffer RAM and the control block. It plays the list once per start strobe, or continuously in loop mode.

Parameters:
ADDR_WIDTH, 10, display-list address width (list depth 2^ADDR_WIDTH words)
LIST_BASE, 0, address of the first word of the list

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle strobe; begins playback at LIST_BASE when idle
stop  input  1  level; abort playback at the next command boundary
loop  input  1  level; sampled at HALT, 1 = restart at LIST_BASE
mem_addr  output  ADDR_WIDTH  display-list read address
mem_rd  output  1  read enable; data valid on mem_data in the following cycle
mem_data  input  26  list word: [25:24] opcode, [23:12] x, [11:0] y
x  output  12  x coordinate to control block
y  output  12  y coordinate to control block
jump  output  1  one-cycle move-without-draw strobe
draw  output  1  one-cycle line-draw strobe
ready  input  1  control block can accept a command
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when a pass ends (HALT, stop, or overrun)
overrun  output  1  sticky; set when the address wraps without a HALT; cleared by start

Behaviour:
- Reset values (async): state IDLE; mem_addr=LIST_BASE; mem_rd=0; x=y=0; jump=draw=0; busy=0; done=0; overrun=0.
- Opcodes:
  - 00 JUMP
  - 01 DRAW
  - 10 HALT (end of list)
  - 11 NOP (skip, no strobe)
- FSM states: IDLE, FETCH, LATCH, ISSUE, SETTLE.
- IDLE: start=1 -> FETCH, mem_addr=LIST_BASE, overrun cleared. start is ignored while busy.
- FETCH: mem_rd=1 for exactly one cycle -> LATCH.
- LATCH: capture mem_data into an internal word register, then:
  - HALT -> pass end.
  - NOP -> advance address, then FETCH.
  - JUMP/DRAW -> ISSUE.
- ISSUE: wait for ready=1. In the cycle ready=1:
  - drive x/y from the latched word together with a one-cycle jump (op 00) or draw (op 01);
  - advance the address;
  - go to SETTLE.
  - jump and draw are never high together.
- SETTLE: exactly one cycle in which ready is ignored, because the control block drops ready one cycle after a strobe. Then FETCH.
- x/y: update only in the strobe cycle and hold until the next strobe, because the control block samples them after the strobe.
- Minimum spacing between strobes is 4 cycles (ISSUE, SETTLE, FETCH, LATCH).
- Address advance: mem_addr+1 modulo 2^ADDR_WIDTH. If the advance wraps back to LIST_BASE, set overrun and end the pass (no loop), even if the word just issued was valid.
- Pass end:
  - done pulses one cycle.
  - loop=1 and no overrun -> FETCH at LIST_BASE.
  - Otherwise -> IDLE.
- stop=1 is checked in LATCH and ISSUE only.
  - A strobe already issued completes normally.
  - A pending (unissued) command is dropped; done pulses and the FSM goes to IDLE.
- start and stop asserted together in IDLE: stop wins, remain IDLE.
- Reset mid-pass: immediate return to reset values. Any strobe in flight is cut.
- ready low indefinitely: the FSM holds in ISSUE with no timeout. stop still aborts.

Test Plan:
1. List [JUMP(100,200), DRAW(4095,0), HALT], ready=1, loop=0 -> after start: jump with x=100,y=200, then ≥4 cycles later draw with x=4095,y=0; done pulse; busy=0; exactly 3 mem_rd pulses.
2. Same list with ready held low 20 cycles after the first strobe -> draw is issued in the first cycle ready returns high; x/y stay 100/200 until then.
3. List [NOP, NOP, DRAW(1,1), HALT], loop=1 -> repeating draw(1,1) strobes; done pulses once per pass; no jump ever.
4. ADDR_WIDTH=2, four DRAW words and no HALT -> four draws, then overrun=1, done pulse, IDLE even with loop=1. The next start clears overrun.
5. stop asserted while in ISSUE with ready=0 -> no strobe, done pulse, IDLE. A start in the same cycle as stop is ignored.
6. reset_n low for one cycle in SETTLE mid-pass -> all outputs at reset values asynchronously. After release, IDLE until start.

Source files
------------

// File: rtl/vector_list_player.sv
// Display-list player for the vector control block.
// Each list word is read from synchronous RAM and decoded. JUMP and DRAW
// words become a single-cycle strobe with x/y. HALT ends a pass, and NOP is
// skipped. The list plays once per start, or repeats while loop is high.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; no RAM traffic, no strobes
// FETCH  | mem_rd high for one cycle at mem_addr
// LATCH  | RAM word valid; capture and decode it
// ISSUE  | JUMP/DRAW pending; strobe in the first cycle ready is high
// SETTLE | one dead cycle after a strobe while the control block drops ready
module vector_list_player #(
    parameter int ADDR_WIDTH = 10,
    parameter int LIST_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [25:0]           mem_data,
    output logic [11:0]           x,
    output logic [11:0]           y,
    output logic                  jump,
    output logic                  draw,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(LIST_BASE);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // {draw_not_jump, x[11:0], y[11:0]}. Opcode bit 25 is only needed at decode time.
    logic [24:0]           cmd_q, cmd_d;
    logic [11:0]           x_q, x_d;
    logic [11:0]           y_q, y_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  fire;

    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  wrap;

    // Next list address. Coming back around to the base means no HALT was found.
    assign addr_inc = addr_q + ADDR_WIDTH'(1);
    assign wrap     = (addr_inc == BASE);

    // Sequencing: decode, issue handshake, pass-end and abort handling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop suppresses the start.
                if (start && !stop) begin
                    state_d = ST_FETCH;
                    addr_d  = BASE;
                    ovr_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                cmd_d = mem_data[24:0];
                if (stop) begin
                    done_d  = 1'b1;
                    addr_d  = BASE;
                    state_d = ST_IDLE;
                end else if (mem_data[25:24] == OP_HALT) begin
                    done_d  = 1'b1;
                    addr_d  = BASE;
                    state_d = (loop && !ovr_q) ? ST_FETCH : ST_IDLE;
                end else if (mem_data[25:24] == OP_NOP) begin
                    if (wrap) begin
                        ovr_d   = 1'b1;
                        done_d  = 1'b1;
                        addr_d  = BASE;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_inc;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (stop) begin
                    done_d  = 1'b1;
                    addr_d  = BASE;
                    state_d = ST_IDLE;
                end else if (ready) begin
                    fire = 1'b1;
                    x_d  = cmd_q[23:12];
                    y_d  = cmd_q[11:0];
                    if (wrap) begin
                        // The command still goes out. The pass ends with
                        // overrun, and loop mode does not restart it.
                        ovr_d   = 1'b1;
                        done_d  = 1'b1;
                        addr_d  = BASE;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_inc;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            cmd_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // The strobe must coincide with the ready cycle, so it is combinational.
    // x/y show the new coordinates in that same cycle and then hold.
    assign jump     = fire & ~cmd_q[24];
    assign draw     = fire &  cmd_q[24];
    assign x        = fire ? cmd_q[23:12] : x_q;
    assign y        = fire ? cmd_q[11:0]  : y_q;
    assign mem_addr = addr_q;
    assign mem_rd   = (state_q == ST_FETCH);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overrun  = ovr_q;

endmodule
